// File: rtl/wptr_ctrl_sync.sv
// rtl/wptr_ctrl_sync.sv - write-domain pointer, fill level and full/almost-full/overflow status for an async FIFO
module wptr_ctrl_sync #(
   parameter int ADDRSIZE     = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = 12
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic                ovf_clr,
   input  logic [ADDRSIZE:0]   rptr_gray,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                full,
   output logic                almost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                overflow
);

   localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(2**ADDRSIZE);
   localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_THRESH);

   logic [SYNC_STAGES-1:0][ADDRSIZE:0] sync_q, sync_d;
   logic [ADDRSIZE:0] wbin_q, wbin_d;
   logic [ADDRSIZE:0] wptr_q, wptr_d;
   logic [ADDRSIZE:0] lvl_q, lvl_d;
   logic              full_q, full_d;
   logic              afull_q, afull_d;
   logic              ovf_q, ovf_d;
   logic [ADDRSIZE:0] rptr_s;
   logic [ADDRSIZE:0] rbin_s;
   logic              wen;

   assign rptr_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      rbin_s = '0;
      for (int i = 0; i <= ADDRSIZE; i++) begin
         rbin_s[i] = ^(rptr_s >> i);
      end
   end

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], rptr_gray};
      wen     = winc & ~full_q;
      wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wen};
      wptr_d  = (wbin_d >> 1) ^ wbin_d;
      // Stale read pointer can only make this over-report, never under-report.
      lvl_d   = wbin_d - rbin_s;
      full_d  = (lvl_d == DEPTH_C);
      afull_d = (lvl_d >= AFULL_C);
      ovf_d   = ovf_q;
      if (winc && full_q) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         sync_q  <= '0;
         wbin_q  <= '0;
         wptr_q  <= '0;
         lvl_q   <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         wbin_q  <= wbin_d;
         wptr_q  <= wptr_d;
         lvl_q   <= lvl_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end

   assign waddr       = wbin_q[ADDRSIZE-1:0];
   assign wptr        = wptr_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign wlevel      = lvl_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_ctrl_sync.sv
// tb/tb_wptr_ctrl_sync.sv - directed self-checking bench for wptr_ctrl_sync
module tb_wptr_ctrl_sync;

   logic       wclk = 1'b0;
   logic       wrst, winc, ovf_clr;
   logic [4:0] rptr_gray;
   logic [3:0] waddr;
   logic [4:0] wptr;
   logic       full, almost_full, overflow;
   logic [4:0] wlevel;

   int n_checks = 0;
   int n_fail   = 0;

   wptr_ctrl_sync #(.ADDRSIZE(4), .SYNC_STAGES(2), .AFULL_THRESH(12)) dut (
      .wclk(wclk), .wrst(wrst), .winc(winc), .ovf_clr(ovf_clr),
      .rptr_gray(rptr_gray), .waddr(waddr), .wptr(wptr), .full(full),
      .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
   );

   always #5 wclk = ~wclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] gray(input int b);
      logic [4:0] x;
      x = b[4:0];
      return x ^ (x >> 1);
   endfunction

   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wptr"},  32'(wptr), 0);
      check({tag, "_waddr"}, 32'(waddr), 0);
      check({tag, "_full"},  32'(full), 0);
      check({tag, "_afull"}, 32'(almost_full), 0);
      check({tag, "_wlevel"}, 32'(wlevel), 0);
      check({tag, "_ovf"},   32'(overflow), 0);
   endtask

   initial begin
      logic [4:0] prev;
      int wm;
      int lim;

      // Reset with random inputs
      wrst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         winc = 1'($urandom); ovf_clr = 1'($urandom); rptr_gray = 5'($urandom);
         step();
      end
      check_zero("reset");

      // Fill from empty
      wrst = 1'b0; ovf_clr = 1'b0; rptr_gray = 5'd0; winc = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         check("fill_wlevel", 32'(wlevel), 32'(i));
         check("fill_afull", 32'(almost_full), 32'(i >= 12));
         check("fill_full", 32'(full), 32'(i == 16));
         check("fill_waddr", 32'(waddr), 32'(i % 16));
         check("fill_wptr", 32'(wptr), 32'(gray(i)));
      end
      check("full_wptr", 32'(wptr), 32'h18);

      // Overflow while full
      for (int i = 0; i < 3; i++) begin
         step();
         check("ovf_wptr", 32'(wptr), 32'h18);
         check("ovf_full", 32'(full), 1);
         check("ovf_flag", 32'(overflow), 1);
         check("ovf_wlevel", 32'(wlevel), 16);
      end
      ovf_clr = 1'b1;
      step();
      check("ovf_set_wins", 32'(overflow), 1);
      winc = 1'b0;
      step();
      check("ovf_clear", 32'(overflow), 0);
      ovf_clr = 1'b0;

      // Read release takes SYNC_STAGES+1 edges
      rptr_gray = 5'b00001;
      step();
      check("rel_full_e1", 32'(full), 1);
      step();
      check("rel_full_e2", 32'(full), 1);
      step();
      check("rel_full_e3", 32'(full), 0);
      check("rel_wlevel", 32'(wlevel), 15);
      check("rel_afull", 32'(almost_full), 1);

      // Reader jumps to lag 4 behind the writer
      rptr_gray = gray(12);
      for (int i = 0; i < 4; i++) step();
      check("lag_wlevel", 32'(wlevel), 4);

      // 40 writes with a reader lagging 4 behind
      wm = 16;
      winc = 1'b1;
      for (int k = 0; k < 40; k++) begin
         prev = wptr;
         rptr_gray = gray(wm - 4);
         step();
         wm++;
         check("wrap_full", 32'(full), 0);
         check("wrap_wptr", 32'(wptr), 32'(gray(wm)));
         check("wrap_onebit", 32'($countones(prev ^ wptr)), 1);
         check("wrap_wlevel", 32'(wlevel), (k == 0) ? 5 : (k == 1) ? 6 : 7);
         if ((wm % 32) == 0) begin
            check("wrap_prev", 32'(prev), 32'h10);
            check("wrap_zero", 32'(wptr), 0);
         end
      end

      // Fill to full again, then overflow, then reset mid-operation
      lim = 0;
      while (!full && lim < 40) begin
         step();
         lim++;
      end
      check("refill_full", 32'(full), 1);
      step();
      check("refill_ovf", 32'(overflow), 1);
      wrst = 1'b1;
      step();
      check_zero("midreset");
      wrst = 1'b0; rptr_gray = 5'd0; winc = 1'b1;
      step();
      check("resume_wptr", 32'(wptr), 1);
      check("resume_waddr", 32'(waddr), 1);
      check("resume_wlevel", 32'(wlevel), 1);
      check("resume_full", 32'(full), 0);
      winc = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
